rffp_addsub_pipe: RTL and testbench

- Pipelined, parametrised RFFP adder/subtractor with valid/ready handshake; successor to the combinational RFFP adder.
- Same word format: {sign, exponent[E-1:0], mantissa[M-1:0]}, total width 1+E+M. No hidden bit, unsigned exponent.
- Adds an add/sub mode, carry normalisation at any exponent difference, exponent saturation, a canonical zero, status flags and a sideband tag.
- Sits between RFFP operand sources (multiplier outputs, accumulator feedback) and result consumers in the datapath.

---
 rtl/rffp_pkg.sv | 26 ++
 rtl/rffp_norm_round.sv | 45 ++++
 rtl/rffp_addsub_pipe.sv | 140 ++++++++++++++
 tb/tb_rffp_addsub_pipe.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rffp_pkg.sv
// Shared RFFP word definitions: field widths, the packed word layout and
// pack/unpack helpers for the default {sign, exp, man} format.
package rffp_pkg;

  localparam int RFFP_E = 8;
  localparam int RFFP_M = 8;
  localparam int RFFP_W = 1 + RFFP_E + RFFP_M;

  typedef struct packed {
    logic              sign;
    logic [RFFP_E-1:0] exp;
    logic [RFFP_M-1:0] man;
  } rffp_t;

  localparam rffp_t RFFP_ZERO    = '0;
  localparam rffp_t RFFP_MAX_MAG = '{sign: 1'b0, exp: '1, man: '1};

  function automatic rffp_t rffp_unpack(input logic [RFFP_W-1:0] word);
    return rffp_t'(word);
  endfunction

  function automatic logic [RFFP_W-1:0] rffp_pack(input rffp_t f);
    return f;
  endfunction

endpackage

// File: rtl/rffp_norm_round.sv
// S3 combinational logic: carry normalisation with round-half-up, exponent
// saturation and canonical-zero packing of a magnitude sum.
module rffp_norm_round
  import rffp_pkg::*;
#(
  parameter int E = RFFP_E,
  parameter int M = RFFP_M
) (
  input  logic         sign,
  input  logic [M:0]   sum,
  input  logic [E-1:0] exp_r,
  output logic [E+M:0] c,
  output logic         ovf,
  output logic         zero
);

  logic [M-1:0] man;
  logic [E-1:0] exp_n;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    man   = sum[M-1:0];
    exp_n = exp_r;
    ovf   = 1'b0;
    zero  = 1'b0;
    c     = '0;
    if (sum[M]) begin
      // sum never exceeds 2^(M+1)-2, so the rounding increment cannot carry out
      man = sum[M:1] + M'(sum[0]);
      if (exp_r == '1) begin
        exp_n = '1;
        man   = '1;
        ovf   = 1'b1;
      end else begin
        exp_n = exp_r + E'(1);
      end
    end
    if (man == '0) begin
      zero = 1'b1;
    end else begin
      c = {sign, exp_n, man};
    end
  end

endmodule

// File: rtl/rffp_addsub_pipe.sv
// Three-stage pipelined RFFP adder/subtractor (align, magnitude add/sub,
// normalise/pack) with valid/ready flow control and a sideband tag.
module rffp_addsub_pipe
  import rffp_pkg::*;
#(
  parameter int RFFP_EXP_WIDTH = RFFP_E,
  parameter int RFFP_MAN_WIDTH = RFFP_M,
  parameter int TAG_WIDTH      = 4,
  parameter int IN_OUT_WIDTH   = RFFP_EXP_WIDTH + RFFP_MAN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_OUT_WIDTH:0] in_a,
  input  logic [IN_OUT_WIDTH:0] in_b,
  input  logic                  in_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IN_OUT_WIDTH:0] out_c,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_ovf,
  output logic                  out_zero
);

  localparam int E = RFFP_EXP_WIDTH;
  localparam int M = RFFP_MAN_WIDTH;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic         sa, sb;
  logic [E-1:0] ea, eb, diff, exp_max;
  logic [M-1:0] ma, mb, ma_al, mb_al;

  always_comb begin
    sa      = in_a[IN_OUT_WIDTH];
    sb      = in_b[IN_OUT_WIDTH] ^ in_op;
    ea      = in_a[IN_OUT_WIDTH-1:M];
    eb      = in_b[IN_OUT_WIDTH-1:M];
    ma      = in_a[M-1:0];
    mb      = in_b[M-1:0];
    ma_al   = ma;
    mb_al   = mb;
    exp_max = ea;
    // Operands stay in their slots; only the smaller-exponent mantissa shifts.
    if (ea >= eb) begin
      diff  = ea - eb;
      mb_al = (32'(diff) >= M) ? '0 : (mb >> diff);
    end else begin
      diff    = eb - ea;
      exp_max = eb;
      ma_al   = (32'(diff) >= M) ? '0 : (ma >> diff);
    end
  end

  logic                 s1_valid, s1_sa, s1_sb;
  logic [M-1:0]         s1_ma, s1_mb;
  logic [E-1:0]         s1_exp;
  logic [TAG_WIDTH-1:0] s1_tag;

  logic       sum_sign;
  logic [M:0] sum;

  always_comb begin
    sum_sign = s1_sa;
    if (s1_sa == s1_sb) begin
      sum = {1'b0, s1_ma} + {1'b0, s1_mb};
    end else if (s1_ma >= s1_mb) begin
      sum = {1'b0, s1_ma - s1_mb};
    end else begin
      sum      = {1'b0, s1_mb - s1_ma};
      sum_sign = s1_sb;
    end
  end

  logic                 s2_valid, s2_sign;
  logic [M:0]           s2_sum;
  logic [E-1:0]         s2_exp;
  logic [TAG_WIDTH-1:0] s2_tag;

  logic [IN_OUT_WIDTH:0] norm_c;
  logic                  norm_ovf, norm_zero;

  rffp_norm_round #(.E(E), .M(M)) u_norm_round (
    .sign  (s2_sign),
    .sum   (s2_sum),
    .exp_r (s2_exp),
    .c     (norm_c),
    .ovf   (norm_ovf),
    .zero  (norm_zero)
  );

  // Control and visible outputs: the whole pipeline advances or holds as one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_tag   <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_c    <= norm_c;
        out_tag  <= s2_tag;
        out_ovf  <= norm_ovf;
        out_zero <= norm_zero;
      end
    end
  end

  // NOTE: internal datapath registers are qualified by their valid bit, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (!stall) begin
      if (in_valid) begin
        s1_sa  <= sa;
        s1_sb  <= sb;
        s1_ma  <= ma_al;
        s1_mb  <= mb_al;
        s1_exp <= exp_max;
        s1_tag <= in_tag;
      end
      if (s1_valid) begin
        s2_sign <= sum_sign;
        s2_sum  <= sum;
        s2_exp  <= s1_exp;
        s2_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_rffp_addsub_pipe.sv
// Directed and scoreboard-checked bench for rffp_addsub_pipe at E=8, M=8.
module tb_rffp_addsub_pipe;
  import rffp_pkg::*;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, in_op;
  logic        out_valid, out_ready, out_ovf, out_zero;
  logic [16:0] in_a, in_b, out_c;
  logic [3:0]  in_tag, out_tag;

  typedef struct {
    logic [16:0] c;
    logic [3:0]  tag;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, failures = 0, n_out = 0, stall_cycles = 0;

  always #5 clk = ~clk;

  rffp_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [16:0] w(input logic s, input logic [7:0] e, input logic [7:0] m);
    rffp_t f;
    f.sign = s;
    f.exp  = e;
    f.man  = m;
    return rffp_pack(f);
  endfunction

  function automatic exp_t ex(input logic [16:0] c, input logic [3:0] tag,
                              input logic ovf, input logic zero);
    exp_t r;
    r.c = c; r.tag = tag; r.ovf = ovf; r.zero = zero;
    return r;
  endfunction

  // Reference model: signed integer arithmetic on the aligned magnitudes.
  function automatic exp_t model(input logic [16:0] a, input logic [16:0] b,
                                 input logic op, input logic [3:0] tag);
    rffp_t fa = rffp_unpack(a);
    rffp_t fb = rffp_unpack(b);
    int ea = int'(fa.exp);
    int eb = int'(fb.exp);
    int ma = int'(fa.man);
    int mb = int'(fb.man);
    int er, d, s, mag, man, e;
    logic sgn, ovf;
    ovf = 1'b0;
    if (ea >= eb) begin
      er = ea; d = ea - eb;
      mb = (d >= 8) ? 0 : mb / (1 << d);
    end else begin
      er = eb; d = eb - ea;
      ma = (d >= 8) ? 0 : ma / (1 << d);
    end
    s   = (fa.sign ? -ma : ma) + ((fb.sign ^ op) ? -mb : mb);
    sgn = (s < 0);
    mag = sgn ? -s : s;
    if (mag >= 256) begin
      man = (mag + 1) / 2;
      e   = er + 1;
      if (e > 255) begin
        e = 255; man = 255; ovf = 1'b1;
      end
    end else begin
      man = mag; e = er;
    end
    if (man == 0) return ex(17'h0, tag, 1'b0, 1'b1);
    return ex({sgn, 8'(e), 8'(man)}, tag, ovf, 1'b0);
  endfunction

  task automatic drive(input logic [16:0] a, input logic [16:0] b, input logic op,
                       input logic [3:0] tag, input exp_t e);
    bit ok = 0;
    in_a = a; in_b = b; in_op = op; in_tag = tag; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    check("accept_within_budget", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) sb_q.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb_q.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_scoreboard_empty", 32'(sb_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !out_ready) begin
        stall_cycles++;
        check("in_ready_during_stall", 32'(in_ready), 32'd0);
      end
      if (out_valid && out_ready) begin
        n_out++;
        check("result_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_c",    32'(out_c),    32'(e.c));
          check("out_tag",  32'(out_tag),  32'(e.tag));
          check("out_ovf",  32'(out_ovf),  32'(e.ovf));
          check("out_zero", 32'(out_zero), 32'(e.zero));
        end
      end
    end
  end

  initial begin
    int lat;
    int n_before;
    logic [16:0] ra, rb;
    logic        rop;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_c",     32'(out_c),     32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);

    // Equal exponents with carry, and the 3-cycle latency.
    drive(w(0, 8'h05, 8'h80), w(0, 8'h05, 8'h80), 1'b0, 4'd1,
          ex(w(0, 8'h06, 8'h80), 4'd1, 1'b0, 1'b0));
    lat = 1;
    while (lat < 10 && !out_valid) begin
      @(posedge clk);
      #1 lat++;
    end
    check("latency", 32'(lat), 32'd3);
    drain();

    // Carry at unequal exponents, exact cancel, sign from larger magnitude,
    // round half up, shift past M, exponent saturation.
    drive(w(0, 8'h0A, 8'hF0), w(0, 8'h08, 8'h40), 1'b0, 4'd2,
          ex(w(0, 8'h0B, 8'h80), 4'd2, 1'b0, 1'b0));
    drive(w(0, 8'h04, 8'h30), w(0, 8'h04, 8'h30), 1'b1, 4'd3,
          ex(17'h0, 4'd3, 1'b0, 1'b1));
    drive(w(1, 8'h02, 8'h10), w(1, 8'h02, 8'h30), 1'b1, 4'd4,
          ex(w(0, 8'h02, 8'h20), 4'd4, 1'b0, 1'b0));
    drive(w(0, 8'h03, 8'h81), w(0, 8'h03, 8'h80), 1'b0, 4'd5,
          ex(w(0, 8'h04, 8'h81), 4'd5, 1'b0, 1'b0));
    drive(w(0, 8'h03, 8'h10), w(0, 8'h0C, 8'h01), 1'b0, 4'd6,
          ex(w(0, 8'h0C, 8'h01), 4'd6, 1'b0, 1'b0));
    drive(w(0, 8'hFF, 8'hFF), w(0, 8'hFF, 8'hFF), 1'b0, 4'd7,
          ex(w(0, 8'hFF, 8'hFF), 4'd7, 1'b1, 1'b0));
    drain();

    // Back-to-back stream with a 4-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        out_ready = 1'b0;
        fork
          begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b1;
          end
        join_none
      end
      ra  = 17'($urandom());
      rb  = (i % 2 == 0) ? {ra[16], ra[15:8] - 8'(i), 8'($urandom())} : 17'($urandom());
      rop = 1'($urandom());
      drive(ra, rb, rop, 4'(i), model(ra, rb, rop, 4'(i)));
    end
    drain();
    check("stall_cycles", 32'(stall_cycles), 32'd4);

    // Reset with two operations in flight.
    drive(w(0, 8'h10, 8'h11), w(0, 8'h10, 8'h22), 1'b0, 4'd8,
          ex(w(0, 8'h10, 8'h33), 4'd8, 1'b0, 1'b0));
    drive(w(0, 8'h20, 8'h44), w(0, 8'h20, 8'h11), 1'b1, 4'd9,
          ex(w(0, 8'h20, 8'h33), 4'd9, 1'b0, 1'b0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("out_valid_after_mid_reset", 32'(out_valid), 32'd0);
    rst = 1'b0;
    sb_q.delete();
    n_before = n_out;
    repeat (10) @(posedge clk);
    #1;
    check("no_output_after_reset", 32'(n_out), 32'(n_before));
    check("out_valid_idle_after_reset", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
